// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Function : Round-robin arbiter sharing the single write port of the 16x8
//            async FIFO between NUM_REQ producers, in the write-clock domain.
//            Grants one requester per burst of up to BURST_LEN words, honours
//            FIFO full back-pressure and rotates priority after each burst.
// Options  : define ARB_PRIO0_EN to give requester 0 absolute priority in IDLE
//            (requesters 1..NUM_REQ-1 still rotate among themselves).
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4
) (
    input  logic                      w_clk,
    input  logic                      w_rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        accept,
    output logic                      w_en,
    output logic [DATA_W-1:0]         d_in,
    input  logic                      full,
    output logic                      busy
);

    localparam int OW = $clog2(NUM_REQ);
    localparam int CW = $clog2(BURST_LEN) + 1;
    localparam logic [CW-1:0] C_LAST_BEAT = CW'(BURST_LEN - 1);
    localparam logic [OW-1:0] C_LAST_REQ  = OW'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [OW-1:0]       owner_q, owner_d;
    logic [OW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]       beat_cnt_q, beat_cnt_d;

    logic                pick_found;
    logic [OW-1:0]       pick_idx;
    logic [OW:0]         cand_sum;
    logic [OW-1:0]       cand;
    logic                req_own;
    logic                last_own;
    logic [DATA_W-1:0]   data_own;
    logic                w_en_int;
    logic                burst_end;

    // Owner selection in IDLE: first requester at or above rr_ptr, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand_sum   = '0;
        cand       = '0;
`ifdef ARB_PRIO0_EN
        // Requester 0 wins outright; otherwise the rotating search below
        // naturally skips bit 0 because it is clear.
        if (req[0]) begin
            pick_found = 1'b1;
        end
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_sum = {1'b0, rr_ptr_q} + (OW+1)'(k);
            if (cand_sum >= (OW+1)'(NUM_REQ)) begin
                cand_sum = cand_sum - (OW+1)'(NUM_REQ);
            end
            cand = cand_sum[OW-1:0];
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Mux the current owner's request, last flag and data.
    always_comb begin
        req_own  = 1'b0;
        last_own = 1'b0;
        data_own = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == OW'(i)) begin
                req_own  = req[i];
                last_own = req_last[i];
                data_own = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Write strobe is gated by reset so no word is written in a reset cycle.
    assign w_en_int  = (state_q == BURST) & req_own & ~full & ~w_rst;
    assign burst_end = (state_q == BURST) &
                       ((w_en_int & ((beat_cnt_q == C_LAST_BEAT) | last_own)) | ~req_own);

    assign w_en   = w_en_int;
    assign d_in   = ((state_q == BURST) && !w_rst) ? data_own : '0;
    assign accept = gnt_q & {NUM_REQ{w_en_int}};
    assign gnt    = gnt_q;
    assign busy   = (state_q == BURST);

    // Next-state logic: grant in IDLE, count beats and release in BURST.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (pick_found) begin
                    state_d    = BURST;
                    owner_d    = pick_idx;
                    gnt_d      = NUM_REQ'(1) << pick_idx;
                    beat_cnt_d = '0;
                end
            end
            BURST: begin
                if (w_en_int) begin
                    beat_cnt_d = beat_cnt_q + CW'(1);
                end
                if (burst_end) begin
                    state_d = IDLE;
                    gnt_d   = '0;
`ifdef ARB_PRIO0_EN
                    if (owner_q != '0) begin
                        rr_ptr_d = (owner_q == C_LAST_REQ) ? '0 : owner_q + OW'(1);
                    end
`else
                    rr_ptr_d = (owner_q == C_LAST_REQ) ? '0 : owner_q + OW'(1);
`endif
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Function : Scoreboard bench for fifo_wr_arbiter. Stimulus pushes expected
//            FIFO writes into a queue; a negedge monitor pops and compares on
//            every write. Build with ARB_PRIO0_EN to match a priority-0 DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;

    logic                      w_clk = 1'b0;
    logic                      w_rst;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        accept;
    logic                      w_en;
    logic [DATA_W-1:0]         d_in;
    logic                      full;
    logic                      busy;

    int total = 0;
    int bad   = 0;

    logic [11:0] sb[$];
    logic [11:0] exp_w;
    logic        mon_en;
    logic        src_clr;
    logic [3:0]  cnt[NUM_REQ];
    logic [4:0]  last_idx[NUM_REQ];

    fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .BURST_LEN(4)) dut (
        .w_clk    (w_clk),
        .w_rst    (w_rst),
        .req      (req),
        .req_data (req_data),
        .req_last (req_last),
        .gnt      (gnt),
        .accept   (accept),
        .w_en     (w_en),
        .d_in     (d_in),
        .full     (full),
        .busy     (busy)
    );

    always #5 w_clk = ~w_clk;

    // Producer model: requester i offers 0xA0+16*i+word, advancing on accept.
    always @(posedge w_clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (src_clr)        cnt[i] <= 4'h0;
            else if (accept[i]) cnt[i] <= cnt[i] + 4'h1;
        end
    end

    always_comb begin
        req_data = '0;
        req_last = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[i*DATA_W +: DATA_W] = 8'hA0 + 8'(i*16) + {4'h0, cnt[i]};
            req_last[i] = ({1'b0, cnt[i]} == last_idx[i]);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int id, input logic [7:0] d);
        sb.push_back({4'(1 << id), d});
    endtask

    task automatic push_words(input int id, input int first, input int n);
        for (int j = 0; j < n; j++) push(id, 8'hA0 + 8'(id*16) + 8'(first + j));
    endtask

    task automatic tick;
        @(posedge w_clk);
        #1;
    endtask

    task automatic neg;
        @(negedge w_clk);
    endtask

    task automatic do_reset;
        w_rst   = 1'b1;
        src_clr = 1'b1;
        req     = '0;
        full    = 1'b0;
        tick;
        tick;
        w_rst   = 1'b0;
        src_clr = 1'b0;
    endtask

    task automatic chk_drain(input string name);
        chk(name, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    // Monitor: every FIFO write must match the head of the scoreboard.
    always @(negedge w_clk) begin
        if (mon_en) begin
            chk("gnt_onehot0", {31'b0, $onehot0(gnt)}, 32'd1);
            if (w_en || accept != '0) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got accept=%b d_in=%h expected no write", accept, d_in);
                end else begin
                    exp_w = sb.pop_front();
                    chk("write", {20'b0, accept, d_in}, {20'b0, exp_w});
                end
            end
        end
    end

    initial begin
        w_rst   = 1'b1;
        src_clr = 1'b1;
        req     = '0;
        full    = 1'b0;
        mon_en  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) last_idx[i] = 5'h1F;

        // Reset state
        tick;
        mon_en = 1'b1;
        neg;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_wen", 32'(w_en), 32'h0);
        chk("rst_din", 32'(d_in), 32'h0);
        do_reset;

        // Single requester, full 4-word burst
        req = 4'b0001;
        push(0, 8'hA0); push(0, 8'hA1); push(0, 8'hA2); push(0, 8'hA3);
        neg; chk("t1_gnt_p0", 32'(gnt), 32'h0);
        tick; neg;
        chk("t1_gnt_p1", 32'(gnt), 32'h1);
        chk("t1_busy_p1", 32'(busy), 32'h1);
        tick; tick; tick; tick;
        req = 4'b0000;
        neg;
        chk("t1_gnt_end", 32'(gnt), 32'h0);
        chk("t1_busy_end", 32'(busy), 32'h0);
        tick; neg;
        chk("t1_gnt_idle", 32'(gnt), 32'h0);
        chk_drain("t1_drain");

        // All four requesting: rotation 0,1,2,3,0 with one idle cycle between
        do_reset;
        req = 4'b1111;
        push_words(0, 0, 4); push_words(1, 0, 4); push_words(2, 0, 4);
        push_words(3, 0, 4); push_words(0, 4, 4);
        for (int c = 1; c <= 25; c++) begin
            tick;
            if (c == 25) req = 4'b0000;
            neg;
            case (c)
                1:  chk("t2_gnt_b0", 32'(gnt), 32'h1);
                6:  chk("t2_gnt_b1", 32'(gnt), 32'h2);
                11: chk("t2_gnt_b2", 32'(gnt), 32'h4);
                16: chk("t2_gnt_b3", 32'(gnt), 32'h8);
                21: chk("t2_gnt_b4", 32'(gnt), 32'h1);
                5, 10, 15, 20, 25: chk("t2_gnt_gap", 32'(gnt), 32'h0);
                default: ;
            endcase
        end
        tick; neg;
        chk("t2_gnt_after", 32'(gnt), 32'h0);
        chk_drain("t2_drain");

        // Owner 2 stalled by full for 5 cycles after 2 words
        do_reset;
        req = 4'b0100;
        push(2, 8'hC0); push(2, 8'hC1); push(2, 8'hC2); push(2, 8'hC3);
        tick; neg; chk("t3_gnt", 32'(gnt), 32'h4);
        tick;
        tick;
        full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            neg;
            chk("t3_stall_wen", 32'(w_en), 32'h0);
            chk("t3_stall_acc", 32'(accept), 32'h0);
            chk("t3_stall_gnt", 32'(gnt), 32'h4);
            tick;
        end
        full = 1'b0;
        tick;
        neg; chk("t3_gnt_last", 32'(gnt), 32'h4);
        tick;
        req = 4'b0000;
        neg; chk("t3_gnt_end", 32'(gnt), 32'h0);
        chk_drain("t3_drain");

        // req_last ends burst early; pointer wraps to requester 0
        do_reset;
        last_idx[1] = 5'd1;
        req = 4'b0010;
        push(1, 8'hB0); push(1, 8'hB1);
        push(0, 8'hA0); push(0, 8'hA1); push(0, 8'hA2); push(0, 8'hA3);
        tick; neg; chk("t4_gnt1", 32'(gnt), 32'h2);
        tick; neg; chk("t4_gnt1_last", 32'(gnt), 32'h2);
        tick;
        req = 4'b0011;
        neg; chk("t4_gap", 32'(gnt), 32'h0);
        tick; neg; chk("t4_gnt_wrap", 32'(gnt), 32'h1);
        tick; tick; tick; tick;
        req = 4'b0000;
        neg; chk("t4_gnt_end", 32'(gnt), 32'h0);
        chk_drain("t4_drain");
        last_idx[1] = 5'h1F;

        // Reset pulse during owner 3's second word
        do_reset;
        req = 4'b1000;
        push(3, 8'hD0);
        tick; neg; chk("t5_gnt", 32'(gnt), 32'h8);
        tick;
        w_rst = 1'b1;
        neg;
        chk("t5_rst_wen", 32'(w_en), 32'h0);
        chk("t5_rst_acc", 32'(accept), 32'h0);
        chk("t5_rst_din", 32'(d_in), 32'h0);
        tick;
        w_rst = 1'b0;
        req   = 4'b0000;
        neg;
        chk("t5_gnt_after", 32'(gnt), 32'h0);
        chk("t5_busy_after", 32'(busy), 32'h0);
        chk_drain("t5_drain");

        // Late request from 0 during owner 1's burst; withdrawal ends a burst
        do_reset;
        req = 4'b1110;
        push_words(1, 0, 4);
        tick; neg; chk("t6_gnt1", 32'(gnt), 32'h2);
        tick;
        req = 4'b1111;
        tick; neg; chk("t6_ignore_nonowner", 32'(gnt), 32'h2);
        tick;
        tick; neg; chk("t6_gap", 32'(gnt), 32'h0);
        tick;
        req = 4'b0000;
        neg;
`ifdef ARB_PRIO0_EN
        chk("t6_next_gnt", 32'(gnt), 32'h1);
`else
        chk("t6_next_gnt", 32'(gnt), 32'h4);
`endif
        chk("t6_withdraw_wen", 32'(w_en), 32'h0);
        tick; neg;
        chk("t6_withdraw_gnt", 32'(gnt), 32'h0);
        chk_drain("t6_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
